// File: rtl/mem_access_ctrl.sv
// Load/store initiator between execute stage and a word-organised data memory.
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module mem_access_ctrl #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  localparam logic [2:0] CntInit = 3'(RD_LATENCY - 1);

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_size;
  logic        r_signed, r_err;
  logic [2:0]  r_cnt;

  logic        w_accept, w_misalign;
  logic [31:0] w_wdata, w_load;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept = req_valid && (r_state == StIdle);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lane placement, little-endian; low address bits below the access size are ignored.
  always_comb begin
    w_wdata = req_wdata;
    w_wstrb = 4'b1111;
    case (req_size)
      2'b00: begin
        w_wdata = {4{req_wdata[7:0]}};
        w_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{req_wdata[15:0]}};
        w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    case (r_size)
      2'b00:   w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
      2'b01:   w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wdata  <= w_wdata;
      r_wstrb  <= w_wstrb;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_rdata  <= '0;
      r_err    <= w_misalign;
      r_cnt    <= CntInit;
    end else if (r_state == StRead) begin
      if (r_cnt == 3'd0) begin
        r_rdata <= w_load;
      end else begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Outputs decode purely from state so reset clears them without a clock edge.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (w_misalign)     w_state_next = StResp;
          else if (req_write) w_state_next = StWrite;
          else                w_state_next = StRead;
        end
      end
      StWrite: begin
        mem_addr     = {r_addr[31:2], 2'b00};
        mem_wdata    = r_wdata;
        mem_wstrb    = r_wstrb;
        mem_write    = 1'b1;
        w_state_next = StResp;
      end
      StRead: begin
        mem_addr = {r_addr[31:2], 2'b00};
        mem_read = 1'b1;
        if (r_cnt == 3'd0) w_state_next = StResp;
      end
      StResp: begin
        resp_valid   = 1'b1;
        resp_rdata   = r_rdata;
        resp_err     = r_err;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance with RD_LATENCY=1, one with RD_LATENCY=3,
// sharing request fields and a small word memory model.
module tb_mem_access_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic        reset_n;
  logic        v1, v3;
  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_rdata;

  logic        rdy1, resp_v1, err1, busy1, mw1, mr1;
  logic [31:0] rdata1, maddr1, mwdata1;
  logic [3:0]  wstrb1;
  logic        rdy3, resp_v3, err3, busy3, mw3, mr3;
  logic [31:0] rdata3, maddr3, mwdata3;
  logic [3:0]  wstrb3;

  mem_access_ctrl #(.RD_LATENCY(1)) u_lat1 (
    .sysclk(sysclk), .reset_n(reset_n), .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_v1),
    .resp_rdata(rdata1), .resp_err(err1), .busy(busy1), .mem_addr(maddr1),
    .mem_wdata(mwdata1), .mem_wstrb(wstrb1), .mem_write(mw1), .mem_read(mr1),
    .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.RD_LATENCY(3)) u_lat3 (
    .sysclk(sysclk), .reset_n(reset_n), .req_valid(v3), .req_ready(rdy3),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_v3),
    .resp_rdata(rdata3), .resp_err(err3), .busy(busy3), .mem_addr(maddr3),
    .mem_wdata(mwdata3), .mem_wstrb(wstrb3), .mem_write(mw3), .mem_read(mr3),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:63];
  assign mem_rdata = mr3 ? mem[maddr3[7:2]] : mem[maddr1[7:2]];

  always @(posedge sysclk) begin
    for (int i = 0; i < 4; i++) begin
      if (mw1 && wstrb1[i]) mem[maddr1[7:2]][8*i +: 8] = mwdata1[8*i +: 8];
      if (mw3 && wstrb3[i]) mem[maddr3[7:2]][8*i +: 8] = mwdata3[8*i +: 8];
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse pops one expected entry.
  always @(negedge sysclk) begin
    if (resp_v1 || resp_v3) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_v1 ? rdata1 : rdata3, mon_e.rdata);
        chk("resp_err", {31'b0, resp_v1 ? err1 : err3}, {31'b0, mon_e.err});
      end
    end else begin
      chk("idle_rdata", rdata1 | rdata3, 32'h0);
    end
  end

  // Called at a negedge; returns 1 time unit after the accepting edge.
  task automatic do_req(input bit use3, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit push,
                        input logic [31:0] er, input bit ee);
    int n = 0;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    if (use3) v3 = 1'b1;
    else      v1 = 1'b1;
    while (!(use3 ? rdy3 : rdy1) && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 for 20 cycles expected ready=1");
      v1 = 1'b0;
      v3 = 1'b0;
      return;
    end
    if (push) sb.push_back({er, ee});
    @(posedge sysclk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  localparam logic [31:0] LaneAddr [8] = '{32'h13, 32'h13, 32'h12, 32'h10,
                                           32'h11, 32'h12, 32'h10, 32'h12};
  localparam logic [1:0]  LaneSize [8] = '{2'b00, 2'b00, 2'b01, 2'b00,
                                           2'b00, 2'b00, 2'b01, 2'b01};
  localparam bit          LaneSgn  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] LaneExp  [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                           32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                           32'h00007F01, 32'h000080FF};

  initial begin
    reset_n = 1'b0;
    v1 = 1'b0; v3 = 1'b0;
    req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;

    #3;
    chk("rst_ready", {31'b0, rdy1}, 32'h1);
    chk("rst_busy", {31'b0, busy1}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_v1}, 32'h0);
    chk("rst_resp_err", {31'b0, err1}, 32'h0);
    chk("rst_mem_addr", maddr1, 32'h0);
    chk("rst_mem_wdata", mwdata1, 32'h0);
    chk("rst_mem_wstrb", {28'b0, wstrb1}, 32'h0);
    chk("rst_mem_rw", {30'b0, mw1, mr1}, 32'h0);
    chk("rst_ready_lat3", {31'b0, rdy3}, 32'h1);
    @(negedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);

    // Word store then word load, latency 1
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    @(negedge sysclk);
    chk("st_mem_write", {31'b0, mw1}, 32'h1);
    chk("st_wstrb", {28'b0, wstrb1}, 32'hF);
    chk("st_mem_addr", maddr1, 32'h10);
    chk("st_mem_wdata", mwdata1, 32'hDEADBEEF);
    chk("st_ready_low", {30'b0, rdy1, busy1}, 32'h1);
    @(negedge sysclk);
    chk("st_resp_n2", {31'b0, resp_v1}, 32'h1);
    chk("st_write_once", {27'b0, mw1, wstrb1}, 32'h0);

    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge sysclk);
    chk("ld_mem_read", {31'b0, mr1}, 32'h1);
    chk("ld_mem_addr", maddr1, 32'h10);
    @(negedge sysclk);
    chk("ld_resp_n2", {31'b0, resp_v1}, 32'h1);
    chk("ld_read_off", {31'b0, mr1}, 32'h0);

    // Byte/halfword lane extraction
    mem[4] = 32'h80FF7F01;
    for (int i = 0; i < 8; i++) begin
      do_req(1'b0, 1'b0, LaneSize[i], LaneSgn[i], LaneAddr[i], 32'h0, 1'b1, LaneExp[i], 1'b0);
      @(negedge sysclk);
      @(negedge sysclk);
    end

    // Sub-word stores
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AB, 1'b1, 32'h0, 1'b0);
    @(negedge sysclk);
    chk("stb_wstrb", {28'b0, wstrb1}, 32'h4);
    chk("stb_wdata", mwdata1, 32'hABABABAB);
    chk("stb_addr", maddr1, 32'h20);
    @(negedge sysclk);
    do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h26, 32'h9999BEEF, 1'b1, 32'h0, 1'b0);
    @(negedge sysclk);
    chk("sth_wstrb", {28'b0, wstrb1}, 32'hC);
    chk("sth_wdata", mwdata1, 32'hBEEFBEEF);
    chk("sth_addr", maddr1, 32'h24);
    @(negedge sysclk);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 32'h00AB0000, 1'b0);
    @(negedge sysclk);
    @(negedge sysclk);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 1'b1, 32'hBEEF0000, 1'b0);
    @(negedge sysclk);
    @(negedge sysclk);

    // Misaligned accesses
`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge sysclk);
    chk("mis_resp_n1", {31'b0, resp_v1}, 32'h1);
    chk("mis_no_read", {30'b0, mr1, mw1}, 32'h0);
    @(negedge sysclk);
    chk("mis_no_read_after", {30'b0, mr1, mw1}, 32'h0);
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1'b1);
    @(negedge sysclk);
    chk("mis_half_no_read", {31'b0, mr1}, 32'h0);
    @(negedge sysclk);
`else
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h11223344, 1'b0);
    @(negedge sysclk);
    chk("mis_read", {31'b0, mr1}, 32'h1);
    chk("mis_aligned_addr", maddr1, 32'h04);
    @(negedge sysclk);
    chk("mis_resp_n2", {31'b0, resp_v1}, 32'h1);
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b1, 32'h00007F01, 1'b0);
    @(negedge sysclk);
    @(negedge sysclk);
`endif

    // Latency 3 load
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'h80FF7F01, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge sysclk);
      chk("l3_mem_read", {31'b0, mr3}, 32'h1);
      chk("l3_ready_low", {31'b0, rdy3}, 32'h0);
      chk("l3_no_resp", {31'b0, resp_v3}, 32'h0);
    end
    @(negedge sysclk);
    chk("l3_resp_n4", {31'b0, resp_v3}, 32'h1);
    chk("l3_read_off", {31'b0, mr3}, 32'h0);
    chk("l3_ready_n4", {31'b0, rdy3}, 32'h0);
    @(negedge sysclk);
    chk("l3_ready_back", {31'b0, rdy3}, 32'h1);

    // Reset during READ cycle 2
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge sysclk);
    @(negedge sysclk);
    chk("rr_read_c2", {31'b0, mr3}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rr_async_read", {31'b0, mr3}, 32'h0);
    chk("rr_async_addr", maddr3, 32'h0);
    chk("rr_async_busy", {31'b0, busy3}, 32'h0);
    chk("rr_async_ready", {31'b0, rdy3}, 32'h1);
    @(negedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (6) @(negedge sysclk);
    chk("rr_ready_after", {31'b0, rdy3}, 32'h1);

    // Store aborted by reset before its write edge
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ra_write_off", {27'b0, mw1, wstrb1}, 32'h0);
    @(negedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("ra_no_write", mem[12], 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator that sits between the execute stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake. It drives the word-organised data memory port: word-aligned address, replicated write data, byte strobes, and read/write strobes. For loads it waits a configurable read latency, then extracts and sign- or zero-extends the addressed byte, halfword or word and returns it as a single-cycle response.

## Interface
- RD_LATENCY, 1, cycles `mem_read` is held high; `mem_rdata` is sampled on the last of these cycles (legal range 1..8)
- sysclk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  misaligned-access error, qualified by `resp_valid`
- busy  out  1  high in every state except IDLE
- mem_addr  out  32  `{req_addr[31:2], 2'b00}`
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; bit i selects `mem_wdata[8i+7:8i]`
- mem_write  out  1  write strobe; memory writes on the rising edge where it is high
- mem_read  out  1  read strobe
- mem_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, latch `req_*`.
  - Next state is WRITE for a store, READ for a load, or RESP with the error flag for a trapped misalign.
- WRITE: `mem_write`=1 for exactly one cycle, then RESP.
- READ:
  - `mem_read`=1 for RD_LATENCY cycles, tracked by a down-counter.
  - On the final cycle, capture `mem_rdata`, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then IDLE. There is no response back-pressure.
- Store lanes (little-endian):
  - Byte: `wdata[7:0]` replicated ×4; `mem_wstrb` = `4'b0001 << addr[1:0]`.
  - Halfword: `wdata[15:0]` replicated ×2; `mem_wstrb` = `4'b0011` if `addr[1]`=0, else `4'b1100`.
  - Word: `mem_wstrb` = `4'b1111`.
  - `mem_wstrb`=0 whenever `mem_write`=0.
- Load extraction:
  - Byte lane selected by `addr[1:0]`; halfword lane by `addr[1]`.
  - Extend to 32 bits per `req_signed`.
  - Word loads ignore `req_signed`.
- Reserved size 11 is treated as word.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable from WRITE/READ entry until the state is left; all are 0 in IDLE.
- `resp_rdata` and `resp_err` are 0 whenever `resp_valid`=0.

## Timing
- Request accepted on edge N.
- Store: `mem_write` high in cycle N+1; `resp_valid` in cycle N+2.
- Load: `mem_read` high in cycles N+1..N+RD_LATENCY; `resp_valid` in cycle N+RD_LATENCY+1.
- Trapped misalign: `resp_valid` with `resp_err`=1 in cycle N+1; no memory strobe is ever asserted.
- `req_ready` is high only in IDLE. The earliest back-to-back accept is in the cycle after RESP, so peak throughput is 1 store per 3 cycles.
- `req_valid` while not ready: ignored; the request must be held by the source.
- Reset values: `req_ready`=1; `busy`, `resp_valid`, `resp_rdata`, `resp_err`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_write`, `mem_read` all 0; state IDLE.
- Reset asserted mid-access:
  - Outputs go to their reset values immediately, without waiting for the clock edge.
  - The in-flight access is dropped and no response is issued.
  - A store aborted before its `mem_write` edge must not write.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword with `addr[0]`=1, or a word/reserved size with `addr[1:0]`≠0, is misaligned.
  - A misaligned request goes IDLE→RESP.
  - The response is `resp_err`=1, `resp_rdata`=0, with no memory access.
- `MISALIGN_TRAP_EN` undefined:
  - Misaligned low address bits are ignored: `addr[0]` for halfword, `addr[1:0]` for word.
  - The access proceeds as if aligned.
  - `resp_err` is tied to 0.

## Test plan
- Word store then load, RD_LATENCY=1:
  - Store 0xDEADBEEF to 0x10 → `mem_write` one cycle, `mem_wstrb`=1111, `mem_addr`=0x10.
  - Load word 0x10 → `resp_rdata`=0xDEADBEEF in cycle N+2.
- Byte lanes, with memory word 0x80FF7F01:
  - Signed byte load at 0x13 → 0xFFFFFF80.
  - Unsigned byte load at 0x13 → 0x00000080.
  - Signed halfword load at 0x12 → 0xFFFF80FF.
- Byte store 0xAB to 0x22 → `mem_wstrb`=0100, `mem_wdata`=0xABABABAB, `mem_addr`=0x20.
- Misaligned word load at 0x06:
  - Trap enabled → `resp_err`=1 in cycle N+1, `mem_read` never high.
  - Trap disabled → reads 0x04, `resp_err`=0.
- RD_LATENCY=3 load → `mem_read` high exactly 3 cycles, `resp_valid` at N+4; `req_ready` low from N+1 through N+4.
- `reset_n` pulled low during READ cycle 2 → all outputs 0 asynchronously; after release `req_ready`=1 and no `resp_valid` pulse.
